// File: rtl/mem_arbiter_2m.sv
// Two-master round-robin arbiter for a single native memory port.
// One transaction per grant, a mandatory idle cycle between grants, and a
// per-transaction watchdog that answers the master with an error word if
// the slave never responds.
module mem_arbiter_2m #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        timeout
);

  // A zero timeout disables the watchdog; the counter then keeps one bit.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]    state;
  logic          last;
  logic [CW-1:0] cnt;
  logic          done;
  logic          expire;

  // Route the owning master onto the slave port; everything is zero when idle.
  always_comb begin
    s_valid = 1'b0;
    s_instr = 1'b0;
    s_addr  = 32'h0;
    s_wdata = 32'h0;
    s_wstrb = 4'h0;
    grant   = 2'b00;
    case (state)
      GNT0: begin
        s_valid = m0_valid;
        s_instr = m0_instr;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
        grant   = 2'b01;
      end
      GNT1: begin
        s_valid = m1_valid;
        s_instr = m1_instr;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
        grant   = 2'b10;
      end
      default: ;
    endcase
  end

  // Completion and watchdog expiry; a real slave answer in the last allowed
  // cycle takes precedence over the timeout.
  always_comb begin
    done   = s_valid && s_ready;
    expire = TO_EN && s_valid && !s_ready && (cnt == TO_LIMIT);
  end

  // Responses only reach the owner; rdata substitutes the error word on expiry.
  always_comb begin
    m0_ready = (state == GNT0) && (done || expire);
    m1_ready = (state == GNT1) && (done || expire);
    m0_rdata = ((state == GNT0) && expire) ? ERR_RDATA : s_rdata;
    m1_rdata = ((state == GNT1) && expire) ? ERR_RDATA : s_rdata;
    timeout  = expire;
  end

  // Grant selection, round-robin bookkeeping and the watchdog counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (m0_valid && m1_valid) begin
            state <= last ? GNT0 : GNT1;
          end else if (m0_valid) begin
            state <= GNT0;
          end else if (m1_valid) begin
            state <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (!s_valid) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (done || expire) begin
            state <= IDLE;
            last  <= (state == GNT1);
            cnt   <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2m.sv
// Scoreboard bench for mem_arbiter_2m: stimulus pushes expected grants and
// responses, a monitor pops and compares whenever the arbiter shows them.
module tb_mem_arbiter_2m;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout;

  typedef struct packed {
    logic        master;
    logic [31:0] data;
    logic        to;
  } resp_t;

  resp_t      exp_resp[$];
  logic [1:0] exp_grant[$];
  int         checks = 0;
  int         errors = 0;

  int          ready_at   = 2;
  logic        echo_addr  = 1'b0;
  logic [31:0] slave_data = 32'h0;

  logic        cap_instr;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  mem_arbiter_2m #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Slave read data: either a fixed word or a tag built from the address.
  assign s_rdata = echo_addr ? {16'hC0DE, s_addr[15:0]} : slave_data;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got unexpected event, required none", name);
  endtask

  task automatic push_resp(input logic m, input logic [31:0] d, input logic t);
    resp_t r;
    r.master = m;
    r.data   = d;
    r.to     = t;
    exp_resp.push_back(r);
  endtask

  // Slave model: raises ready in the ready_at-th granted cycle (0 = never).
  initial begin
    int   gcount;
    logic nxt;
    s_ready = 1'b0;
    gcount  = 0;
    forever begin
      @(negedge clk);
      if (reset || !s_valid || s_ready) begin
        gcount = 0;
        nxt    = 1'b0;
      end else begin
        gcount++;
        nxt = (ready_at != 0) && (gcount == ready_at - 1);
      end
      @(posedge clk);
      #1;
      s_ready = reset ? 1'b0 : nxt;
    end
  end

  // Monitor: grant order, idle bubble after each response, response contents.
  initial begin
    logic       prev_ready;
    logic [1:0] prev_grant;
    resp_t      r;
    prev_ready = 1'b0;
    prev_grant = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ready = 1'b0;
        prev_grant = 2'b00;
      end else begin
        if (prev_ready) check_output("idle_bubble", {30'h0, grant}, 32'h0);
        if (grant != 2'b00 && prev_grant == 2'b00) begin
          if (exp_grant.size() == 0) fail_now("unexpected_grant");
          else check_output("grant_seq", {30'h0, grant}, {30'h0, exp_grant.pop_front()});
        end
        if (m0_ready && m1_ready) fail_now("both_ready");
        if (m0_ready || m1_ready) begin
          if (exp_resp.size() == 0) fail_now("unexpected_ready");
          else begin
            r = exp_resp.pop_front();
            check_output("resp_master", {31'h0, m1_ready}, {31'h0, r.master});
            check_output("resp_rdata", m1_ready ? m1_rdata : m0_rdata, r.data);
            check_output("resp_timeout", {31'h0, timeout}, {31'h0, r.to});
          end
        end else if (timeout) begin
          fail_now("stray_timeout");
        end
        prev_ready = m0_ready || m1_ready;
        prev_grant = grant;
      end
    end
  end

  // One transaction from master m; reports the negedge index of the first
  // granted cycle and of the ready cycle, counted from the request cycle.
  task automatic apply_stimulus(input int m, input logic instr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                output int grant_n, output int ready_n);
    logic       other_seen;
    logic [1:0] mine;
    mine       = (m == 0) ? 2'b01 : 2'b10;
    other_seen = 1'b0;
    grant_n    = 0;
    ready_n    = 0;
    @(posedge clk);
    #1;
    if (m == 0) begin
      m0_valid = 1'b1; m0_instr = instr; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end else begin
      m1_valid = 1'b1; m1_instr = instr; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (grant_n == 0 && s_valid && grant == mine) begin
        grant_n   = n;
        cap_instr = s_instr;
        cap_addr  = s_addr;
        cap_wdata = s_wdata;
        cap_wstrb = s_wstrb;
      end
      if ((m == 0) ? m1_ready : m0_ready) other_seen = 1'b1;
      if ((m == 0) ? m0_ready : m1_ready) begin
        ready_n = n;
        break;
      end
    end
    if (ready_n == 0) fail_now("txn_ready_timeout");
    check_output("other_ready_low", {31'h0, other_seen}, 32'h0);
    @(posedge clk);
    #1;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
  endtask

  // Wait for any master ready within a bounded number of cycles.
  task automatic wait_ready(input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now(name);
  endtask

  // Hard stop in case something hangs.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, required finish");
    $fatal(1, "[TB] simulation time limit");
  end

  // Directed test sequence.
  initial begin
    int g, r, cnt;
    int rdy_cyc[4];
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    reset = 1'b1;
    #12;
    check_output("rst_grant", {30'h0, grant}, 32'h0);
    check_output("rst_s_valid", {31'h0, s_valid}, 32'h0);
    check_output("rst_m0_ready", {31'h0, m0_ready}, 32'h0);
    check_output("rst_m1_ready", {31'h0, m1_ready}, 32'h0);
    check_output("rst_timeout", {31'h0, timeout}, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b0;

    // Single read by m0 with a registered-ready slave.
    $display("[TB] single read");
    slave_data = 32'h0000_0005; echo_addr = 1'b0; ready_at = 2;
    exp_grant.push_back(2'b01);
    push_resp(1'b0, 32'h0000_0005, 1'b0);
    apply_stimulus(0, 1'b0, 32'h0000_03FC, 32'h0, 4'h0, g, r);
    check_output("read_s_valid_lat", g, 2);
    check_output("read_ready_lat", r, 3);
    check_output("read_s_addr", cap_addr, 32'h0000_03FC);

    // Write by m1 passes data and strobes straight through.
    $display("[TB] write passthrough");
    slave_data = 32'h0;
    exp_grant.push_back(2'b10);
    push_resp(1'b1, 32'h0, 1'b0);
    apply_stimulus(1, 1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 4'b0011, g, r);
    check_output("write_s_wstrb", {28'h0, cap_wstrb}, 32'h3);
    check_output("write_s_wdata", cap_wdata, 32'hA5A5_A5A5);
    check_output("write_s_addr", cap_addr, 32'h0000_0010);
    check_output("write_ready_lat", r, 3);

    // Both masters request continuously; grants alternate starting with m0.
    $display("[TB] simultaneous requests");
    echo_addr = 1'b1; ready_at = 2;
    exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
    exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
    push_resp(1'b0, 32'hC0DE_0100, 1'b0); push_resp(1'b1, 32'hC0DE_0200, 1'b0);
    push_resp(1'b0, 32'hC0DE_0100, 1'b0); push_resp(1'b1, 32'hC0DE_0200, 1'b0);
    @(posedge clk);
    #1;
    m0_valid = 1'b1; m0_addr = 32'h0000_0100;
    m1_valid = 1'b1; m1_addr = 32'h0000_0200;
    cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        rdy_cyc[cnt] = n;
        cnt++;
        if (cnt == 4) break;
      end
    end
    check_output("rr_count", cnt, 4);
    if (cnt == 4) begin
      check_output("rr_spacing_1", rdy_cyc[1] - rdy_cyc[0], 3);
      check_output("rr_spacing_3", rdy_cyc[3] - rdy_cyc[2], 3);
    end
    @(posedge clk);
    #1;
    m0_valid = 1'b0; m0_addr = 32'h0;
    m1_valid = 1'b0; m1_addr = 32'h0;

    // Slave never answers: error word in the 5th granted cycle.
    $display("[TB] timeout");
    echo_addr = 1'b0; slave_data = 32'h1234_5678; ready_at = 0;
    exp_grant.push_back(2'b01);
    push_resp(1'b0, ERR, 1'b1);
    apply_stimulus(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, g, r);
    check_output("timeout_gnt_cycles", r - g + 1, 5);

    // Slave answers exactly in the 5th granted cycle: real data wins.
    $display("[TB] timeout boundary");
    slave_data = 32'h00C0_FFEE; ready_at = 5;
    exp_grant.push_back(2'b01);
    push_resp(1'b0, 32'h00C0_FFEE, 1'b0);
    apply_stimulus(0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, g, r);
    check_output("boundary_gnt_cycles", r - g + 1, 5);

    // m1 fetch leaves last = 1 so the next tie belongs to m0.
    slave_data = 32'h0000_0077; ready_at = 2;
    exp_grant.push_back(2'b10);
    push_resp(1'b1, 32'h0000_0077, 1'b0);
    apply_stimulus(1, 1'b1, 32'h0000_0080, 32'h0, 4'h0, g, r);
    check_output("fetch_s_instr", {31'h0, cap_instr}, 32'h1);

    // Abort: granted m0 drops valid while the slave is stalled.
    $display("[TB] abort");
    ready_at = 0;
    exp_grant.push_back(2'b01);
    @(posedge clk);
    #1;
    m0_valid = 1'b1; m0_addr = 32'h0000_0090;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    m0_valid = 1'b0;
    @(negedge clk);
    check_output("abort_m0_ready", {31'h0, m0_ready}, 32'h0);
    check_output("abort_s_valid", {31'h0, s_valid}, 32'h0);
    @(negedge clk);
    check_output("abort_idle", {30'h0, grant}, 32'h0);
    echo_addr = 1'b1; ready_at = 2;
    exp_grant.push_back(2'b01);
    push_resp(1'b0, 32'hC0DE_00A0, 1'b0);
    @(posedge clk);
    #1;
    m0_valid = 1'b1; m0_addr = 32'h0000_00A0;
    m1_valid = 1'b1; m1_addr = 32'h0000_00B0;
    wait_ready("abort_tie_ready");
    @(posedge clk);
    #1;
    m0_valid = 1'b0; m0_addr = 32'h0;
    m1_valid = 1'b0; m1_addr = 32'h0;

    // Reset in the middle of a GNT1 grant, then a tie goes to m0.
    $display("[TB] reset mid-grant");
    ready_at = 0;
    @(posedge clk);
    #1;
    m1_valid = 1'b1; m1_addr = 32'h0000_0020;
    @(posedge clk);
    #2;
    check_output("pre_reset_grant", {30'h0, grant}, 32'h2);
    reset = 1'b1;
    #1;
    check_output("mid_rst_grant", {30'h0, grant}, 32'h0);
    check_output("mid_rst_s_valid", {31'h0, s_valid}, 32'h0);
    check_output("mid_rst_m1_ready", {31'h0, m1_ready}, 32'h0);
    m1_valid = 1'b0; m1_addr = 32'h0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    echo_addr = 1'b1; ready_at = 2;
    exp_grant.push_back(2'b01);
    push_resp(1'b0, 32'hC0DE_0030, 1'b0);
    @(posedge clk);
    #1;
    m0_valid = 1'b1; m0_addr = 32'h0000_0030;
    m1_valid = 1'b1; m1_addr = 32'h0000_0040;
    wait_ready("post_reset_ready");
    @(posedge clk);
    #1;
    m0_valid = 1'b0; m0_addr = 32'h0;
    m1_valid = 1'b0; m1_addr = 32'h0;
    repeat (3) @(negedge clk);

    check_output("grant_queue_empty", exp_grant.size(), 0);
    check_output("resp_queue_empty", exp_resp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
